transaction_control: RTL and testbench

Sequencer for a single coin transfer between two players' balances held in the shared single-port balance memory. Launched by the top-level game controller's `start_transaction` level; performs read-read-check-write-write on the memory, triggers the transfer animation, and returns `finished_transaction`. Sits between the main game controller, the balance RAM, and the animation FSM.

---
 rtl/coin_pkg.sv | 11 +
 rtl/balance_alu.sv | 22 ++
 rtl/transaction_control.sv | 115 +++++++++++
 tb/tb_transaction_control.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and defaults for the coin-transfer datapath.
package coin_pkg;
    localparam int BAL_W_DEF = 8;
    localparam int ID_W_DEF  = 1;
    localparam logic [BAL_W_DEF-1:0] BAL_MAX = '1;

    typedef enum logic [3:0] {
        IDLE, RD_SRC, RD_DST, CAP_DST, CHECK,
        WR_SRC, WR_DST, ANIM_REQ, ANIM_WAIT, DONE
    } txn_state_t;
endpackage

// File: rtl/balance_alu.sv
// Combinational transfer arithmetic: debit source, saturating credit to destination.
module balance_alu
    import coin_pkg::*;
#(
    parameter int BAL_W = BAL_W_DEF
) (
    input  logic [BAL_W-1:0] src_bal,
    input  logic [BAL_W-1:0] dst_bal,
    input  logic [BAL_W-1:0] amount,
    input  logic             same_id,
    output logic [BAL_W-1:0] new_src,
    output logic [BAL_W-1:0] new_dst,
    output logic             reject
);
    logic [BAL_W:0] sum;

    // One extra bit so the carry out marks overflow for saturation.
    assign sum     = {1'b0, dst_bal} + {1'b0, amount};
    assign new_dst = sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
    assign new_src = src_bal - amount;
    assign reject  = same_id || (amount > src_bal);
endmodule

// File: rtl/transaction_control.sv
// Sequencer for one coin transfer: read-read-check-write-write, then animation handshake.
module transaction_control
    import coin_pkg::*;
#(
    parameter int BAL_W = BAL_W_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_transaction,
    input  logic [BAL_W-1:0] amount,
    input  logic [ID_W-1:0]  src_id,
    input  logic [ID_W-1:0]  dst_id,
    input  logic [BAL_W-1:0] mem_rdata,
    input  logic             anim_done,
    output logic [ID_W-1:0]  mem_addr,
    output logic [BAL_W-1:0] mem_wdata,
    output logic             mem_we,
    output logic             anim_start,
    output logic             finished_transaction,
    output logic             reject,
    output logic             busy
);
    txn_state_t       state;
    logic [BAL_W-1:0] amt_q, src_bal_q, dst_bal_q, new_src_q, new_dst_q;
    logic [ID_W-1:0]  src_q, dst_q;
    logic             reject_q;
    logic [BAL_W-1:0] alu_new_src, alu_new_dst;
    logic             alu_reject;

    balance_alu #(.BAL_W(BAL_W)) u_alu (
        .src_bal (src_bal_q),
        .dst_bal (dst_bal_q),
        .amount  (amt_q),
        .same_id (src_q == dst_q),
        .new_src (alu_new_src),
        .new_dst (alu_new_dst),
        .reject  (alu_reject)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            amt_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            src_bal_q <= '0;
            dst_bal_q <= '0;
            new_src_q <= '0;
            new_dst_q <= '0;
            reject_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_transaction) begin
                    amt_q    <= amount;
                    src_q    <= src_id;
                    dst_q    <= dst_id;
                    reject_q <= 1'b0;
                    state    <= RD_SRC;
                end
                RD_SRC: state <= RD_DST;
                RD_DST: begin
                    src_bal_q <= mem_rdata;
                    state     <= CAP_DST;
                end
                CAP_DST: begin
                    dst_bal_q <= mem_rdata;
                    state     <= CHECK;
                end
                CHECK: if (alu_reject) begin
                    reject_q <= 1'b1;
                    state    <= DONE;
                end else begin
                    new_src_q <= alu_new_src;
                    new_dst_q <= alu_new_dst;
                    state     <= WR_SRC;
                end
                WR_SRC:    state <= WR_DST;
                WR_DST:    state <= ANIM_REQ;
                ANIM_REQ:  state <= anim_done ? DONE : ANIM_WAIT;
                ANIM_WAIT: if (anim_done) state <= DONE;
                // A held request parks here so it cannot retrigger.
                DONE:      if (!start_transaction) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        anim_start = 1'b0;
        case (state)
            RD_SRC:   mem_addr = src_q;
            RD_DST:   mem_addr = dst_q;
            WR_SRC: begin
                mem_addr  = src_q;
                mem_wdata = new_src_q;
                mem_we    = 1'b1;
            end
            WR_DST: begin
                mem_addr  = dst_q;
                mem_wdata = new_dst_q;
                mem_we    = 1'b1;
            end
            ANIM_REQ: anim_start = 1'b1;
            default: ;
        endcase
    end

    assign finished_transaction = (state == DONE);
    assign busy                 = (state != IDLE);
    assign reject               = reject_q;
endmodule

// File: tb/tb_transaction_control.sv
// Randomized scoreboard bench for transaction_control with a behavioural RAM and animation responder.
module tb_transaction_control;
    localparam int BAL_W = 8;
    localparam int ID_W  = 1;
    localparam int NP    = 2;
    localparam int BMAX  = 255;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             start_transaction = 1'b0;
    logic [BAL_W-1:0] amount = '0;
    logic [ID_W-1:0]  src_id = '0;
    logic [ID_W-1:0]  dst_id = '0;
    logic [BAL_W-1:0] mem_rdata;
    logic             anim_done = 1'b0;
    logic [ID_W-1:0]  mem_addr;
    logic [BAL_W-1:0] mem_wdata;
    logic             mem_we, anim_start, finished_transaction, reject, busy;

    always #5 clock = ~clock;

    transaction_control #(.BAL_W(BAL_W), .ID_W(ID_W)) dut (
        .clock(clock), .resetn(resetn), .start_transaction(start_transaction),
        .amount(amount), .src_id(src_id), .dst_id(dst_id), .mem_rdata(mem_rdata),
        .anim_done(anim_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .anim_start(anim_start),
        .finished_transaction(finished_transaction), .reject(reject), .busy(busy)
    );

    // Single-port synchronous RAM; the bench port lets us preload balances.
    logic [BAL_W-1:0] ram [NP];
    logic             tb_we = 1'b0;
    logic [ID_W-1:0]  tb_addr = '0;
    logic [BAL_W-1:0] tb_wdata = '0;
    always @(posedge clock) begin
        if (tb_we) ram[tb_addr] <= tb_wdata;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    typedef struct {int rej; int lat; int s; int d; int sv; int dv; int c0;} exp_t;
    exp_t q[$];
    int   ref_bal[NP];
    int   anim_delay = 0, anim_timer = -1;
    int   we_cnt = 0, anim_cnt = 0;
    bit   fin_prev = 1'b0;
    exp_t me;

    function void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endfunction

    // Animation responder: pulses anim_done anim_delay cycles after anim_start,
    // otherwise injects random noise that the DUT must ignore.
    always @(negedge clock) begin
        if (anim_start) anim_timer = anim_delay;
        if (anim_timer >= 0) begin
            anim_done = (anim_timer == 0);
            anim_timer--;
        end else begin
            anim_done = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: checks writes and completion against the head of the scoreboard.
    always @(negedge clock) begin
        if (!resetn) begin
            we_cnt = 0; anim_cnt = 0; fin_prev = 1'b0;
        end else begin
            if (mem_we) begin
                if (q.size() == 0) check("we_unexpected", 1, 0);
                else if (we_cnt == 0) begin
                    check("wr_src_addr", int'(mem_addr), q[0].s);
                    check("wr_src_data", int'(mem_wdata), q[0].sv);
                end else begin
                    check("wr_dst_addr", int'(mem_addr), q[0].d);
                    check("wr_dst_data", int'(mem_wdata), q[0].dv);
                end
                we_cnt++;
            end
            if (anim_start) anim_cnt++;
            if (finished_transaction && !fin_prev) begin
                if (q.size() == 0) check("finish_unexpected", 1, 0);
                else begin
                    me = q.pop_front();
                    check("reject", int'(reject), me.rej);
                    check("latency", cyc - me.c0, me.lat);
                    check("we_cycles", we_cnt, me.rej ? 0 : 2);
                    check("anim_pulses", anim_cnt, me.rej ? 0 : 1);
                    check("mem_src", int'(ram[me.s]), me.sv);
                    check("mem_dst", int'(ram[me.d]), me.dv);
                end
                we_cnt = 0; anim_cnt = 0;
            end
            fin_prev = finished_transaction;
        end
    end

    task automatic set_bal(int i, int v);
        @(negedge clock);
        tb_we = 1'b1; tb_addr = ID_W'(i); tb_wdata = BAL_W'(v);
        ref_bal[i] = v;
        @(negedge clock);
        tb_we = 1'b0;
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_addr"}, int'(mem_addr), 0);
        check({tag, "_wdata"}, int'(mem_wdata), 0);
        check({tag, "_we"}, int'(mem_we), 0);
        check({tag, "_anim"}, int'(anim_start), 0);
        check({tag, "_fin"}, int'(finished_transaction), 0);
        check({tag, "_reject"}, int'(reject), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic run_txn(int amt, int s, int d, int delay, bit drop, int hold);
        exp_t e;
        int   t;
        @(negedge clock);
        e.s = s; e.d = d; e.c0 = cyc;
        e.rej = (s == d || amt > ref_bal[s]) ? 1 : 0;
        if (e.rej == 0) begin
            ref_bal[s] = ref_bal[s] - amt;
            ref_bal[d] = (ref_bal[d] + amt > BMAX) ? BMAX : ref_bal[d] + amt;
        end
        e.sv = ref_bal[s]; e.dv = ref_bal[d];
        e.lat = e.rej ? 5 : 8 + delay;
        q.push_back(e);
        amount = BAL_W'(amt); src_id = ID_W'(s); dst_id = ID_W'(d);
        anim_delay = delay; start_transaction = 1'b1;
        @(negedge clock);
        amount = BAL_W'($urandom); src_id = ID_W'($urandom); dst_id = ID_W'($urandom);
        if (drop) start_transaction = 1'b0;
        t = 0;
        while (!finished_transaction && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!finished_transaction) begin
            check("finish_timeout", 0, 1);
            start_transaction = 1'b0;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_finished", int'(finished_transaction), drop ? 0 : 1);
            check("hold_busy", int'(busy), drop ? 0 : 1);
            if (!drop) check("hold_reject", int'(reject), e.rej);
        end
        start_transaction = 1'b0;
        @(negedge clock);
        check("exit_busy", int'(busy), 0);
        check("exit_finished", int'(finished_transaction), 0);
    endtask

    initial begin
        int a, s, d;
        repeat (3) @(negedge clock);
        check_idle_outputs("rst");
        resetn = 1'b1;

        set_bal(0, 50); set_bal(1, 20);
        run_txn(30, 0, 1, 2, 1'b0, 0);
        set_bal(0, 50);
        run_txn(60, 0, 1, 1, 1'b0, 0);
        set_bal(1, 250);
        run_txn(10, 0, 1, 0, 1'b0, 1);
        run_txn(5, 1, 1, 0, 1'b0, 0);

        // Reset while the destination read is in flight.
        @(negedge clock);
        amount = 8'd7; src_id = '0; dst_id = 1'b1; start_transaction = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check_idle_outputs("midrst");
        start_transaction = 1'b0;
        resetn = 1'b1;
        check("midrst_mem0", int'(ram[0]), ref_bal[0]);
        check("midrst_mem1", int'(ram[1]), ref_bal[1]);

        run_txn(3, 1, 0, 1, 1'b0, 20);
        run_txn(4, 0, 1, 3, 1'b1, 2);
        run_txn(0, 1, 0, 0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) set_bal($urandom_range(0, NP - 1), $urandom_range(0, BMAX));
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, BMAX) : $urandom_range(0, 40);
            s = $urandom_range(0, NP - 1);
            d = $urandom_range(0, NP - 1);
            run_txn(a, s, d, $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clock);
        check("queue_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
